// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: state encoding, halt opcode and default widths.
// The decoder and fetch_unit both import this so their field widths agree.
package fetch_unit_pkg;

  localparam int INSTR_W       = 9;
  localparam int PC_W_DEF      = 10;
  localparam int LUT_IDX_W_DEF = 5;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Decoder/host-facing bundle of fetch_unit: run handshake, decoder controls,
// LUT write port and the registered ROM address outputs.
interface fetch_unit_if import fetch_unit_pkg::*; #(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF
) ();

  logic                 Start;
  logic                 Jump;
  logic                 BranchEn;
  logic                 BranchAccept;
  logic                 Halt;
  logic [LUT_IDX_W-1:0] BranchIdx;
  logic                 LutWe;
  logic [LUT_IDX_W-1:0] LutWAddr;
  logic [PC_W-1:0]      LutWData;
  logic [PC_W-1:0]      ProgCtr;
  logic                 InstrValid;
  logic                 Done;

  modport master (
    output Start, Jump, BranchEn, BranchAccept, Halt, BranchIdx,
    output LutWe, LutWAddr, LutWData,
    input  ProgCtr, InstrValid, Done
  );

  modport slave (
    input  Start, Jump, BranchEn, BranchAccept, Halt, BranchIdx,
    input  LutWe, LutWAddr, LutWData,
    output ProgCtr, InstrValid, Done
  );

endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target table: 2^IDX_W absolute PC entries, cleared on reset.
// Gated synchronous write, combinational read (read returns pre-write data).
module fetch_unit_branch_lut #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [PC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// PC sequencer: one instruction per cycle in RUN, next PC registered from halt/jump/branch/increment.
// Falling off the top of ROM parks in DONE rather than wrapping; LUT is only writable outside RUN.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int              PC_W       = PC_W_DEF,
  parameter int              LUT_IDX_W  = LUT_IDX_W_DEF,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic         Clk,
  input  logic         Reset_n,
  fetch_unit_if.slave  bus
);

  localparam logic [PC_W-1:0] PC_MAX = '1;

  fetch_state_t    state;
  logic            lut_we;
  logic            take_target;
  logic [PC_W-1:0] lut_target;

  // Blocking writes during RUN keeps the table stable under the instruction stream.
  assign lut_we      = bus.LutWe && (state != FS_RUN);
  assign take_target = bus.Jump || (bus.BranchEn && bus.BranchAccept);

  fetch_unit_branch_lut #(
    .PC_W  (PC_W),
    .IDX_W (LUT_IDX_W)
  ) u_branch_lut (
    .clk   (Clk),
    .rst_n (Reset_n),
    .we    (lut_we),
    .waddr (bus.LutWAddr),
    .wdata (bus.LutWData),
    .raddr (bus.BranchIdx),
    .rdata (lut_target)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= FS_IDLE;
      bus.ProgCtr    <= '0;
      bus.InstrValid <= 1'b0;
      bus.Done       <= 1'b0;
    end else begin
      case (state)
        FS_IDLE, FS_DONE: begin
          if (bus.Start) begin
            state          <= FS_RUN;
            bus.ProgCtr    <= START_ADDR;
            bus.InstrValid <= 1'b1;
            bus.Done       <= 1'b0;
          end
        end
        FS_RUN: begin
          if (bus.Halt) begin
            state          <= FS_DONE;
            bus.InstrValid <= 1'b0;
            bus.Done       <= 1'b1;
          end else if (take_target) begin
            bus.ProgCtr <= lut_target;
          end else if (bus.ProgCtr == PC_MAX) begin
            state          <= FS_DONE;
            bus.InstrValid <= 1'b0;
            bus.Done       <= 1'b1;
          end else begin
            bus.ProgCtr <= bus.ProgCtr + PC_W'(1);
          end
        end
        default: begin
          state          <= FS_IDLE;
          bus.InstrValid <= 1'b0;
          bus.Done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: expected {ProgCtr, InstrValid, Done} queued per driven cycle,
// observed outputs queued one cycle later, and each scenario task drains and compares both.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int PW = PC_W_DEF;
  localparam int IW = LUT_IDX_W_DEF;

  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_START = 5'b10000;
  localparam logic [4:0] C_JUMP  = 5'b01000;
  localparam logic [4:0] C_BEN   = 5'b00100;
  localparam logic [4:0] C_BACC  = 5'b00010;
  localparam logic [4:0] C_HALT  = 5'b00001;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic          v;
    logic          d;
  } obs_t;

  logic Clk;
  logic Reset_n;
  int   n_assert;
  int   n_fail;
  obs_t exp_q[$];
  obs_t obs_q[$];

  fetch_unit_if bus ();

  fetch_unit dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    {bus.Start, bus.Jump, bus.BranchEn, bus.BranchAccept, bus.Halt} = C_NONE;
    bus.BranchIdx = '0;
    bus.LutWe     = 1'b0;
    bus.LutWAddr  = '0;
    bus.LutWData  = '0;
  endtask

  task automatic capture();
    obs_q.push_back({bus.ProgCtr, bus.InstrValid, bus.Done});
  endtask

  // Drive one cycle of decoder controls and record what the DUT shows after the edge.
  task automatic step(input logic [4:0] ctl, input logic [IW-1:0] idx,
                      input logic [PW-1:0] pc, input logic v, input logic d);
    {bus.Start, bus.Jump, bus.BranchEn, bus.BranchAccept, bus.Halt} = ctl;
    bus.BranchIdx = idx;
    exp_q.push_back({pc, v, d});
    @(posedge Clk);
    #1;
    capture();
  endtask

  task automatic lut_write(input logic [IW-1:0] a, input logic [PW-1:0] data,
                           input logic [PW-1:0] pc, input logic v, input logic d);
    bus.LutWe    = 1'b1;
    bus.LutWAddr = a;
    bus.LutWData = data;
    step(C_NONE, '0, pc, v, d);
    bus.LutWe    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    int   k;
    clear_inputs();
    repeat (2) @(posedge Clk);
    #1;
    exp_q.push_back({PW'(0), 1'b0, 1'b0});
    capture();
    Reset_n = 1'b1;
    step(C_NONE, '0, PW'(0), 1'b0, 1'b0);
    step(C_JUMP | C_BEN | C_BACC, 5'd1, PW'(0), 1'b0, 1'b0);
    step(C_HALT, '0, PW'(0), 1'b0, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got pc=%h valid=%b done=%b, expected pc=%h valid=%b done=%b",
                 k, o.pc, o.v, o.d, e.pc, e.v, e.d);
      end
      k++;
    end
  endtask

  task automatic test_sequential();
    obs_t e, o;
    int   k;
    step(C_START, '0, PW'(0), 1'b1, 1'b0);
    step(C_START, '0, PW'(1), 1'b1, 1'b0);
    for (int i = 2; i <= 4; i++) step(C_NONE, '0, PW'(i), 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sequential[%0d]: got pc=%h valid=%b done=%b, expected pc=%h valid=%b done=%b",
                 k, o.pc, o.v, o.d, e.pc, e.v, e.d);
      end
      k++;
    end
  endtask

  task automatic test_branch();
    obs_t e, o;
    int   k;
    do_reset();
    lut_write(5'd3, 10'h120, PW'(0), 1'b0, 1'b0);
    step(C_START, '0, PW'(0), 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) step(C_NONE, '0, PW'(i), 1'b1, 1'b0);
    step(C_BEN | C_BACC, 5'd3, 10'h120, 1'b1, 1'b0);
    step(C_HALT, '0, 10'h120, 1'b0, 1'b1);
    step(C_START, '0, PW'(0), 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) step(C_NONE, '0, PW'(i), 1'b1, 1'b0);
    step(C_BEN, 5'd3, PW'(6), 1'b1, 1'b0);
    step(C_BACC, 5'd3, PW'(7), 1'b1, 1'b0);
    step(C_NONE, '0, PW'(8), 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL branch[%0d]: got pc=%h valid=%b done=%b, expected pc=%h valid=%b done=%b",
                 k, o.pc, o.v, o.d, e.pc, e.v, e.d);
      end
      k++;
    end
  endtask

  task automatic test_priority();
    obs_t e, o;
    int   k;
    do_reset();
    lut_write(5'd1, 10'h040, PW'(0), 1'b0, 1'b0);
    step(C_START, '0, PW'(0), 1'b1, 1'b0);
    step(C_JUMP | C_BEN | C_BACC, 5'd1, 10'h040, 1'b1, 1'b0);
    step(C_NONE, '0, 10'h041, 1'b1, 1'b0);
    step(C_JUMP, 5'd1, 10'h040, 1'b1, 1'b0);
    step(C_HALT | C_JUMP | C_BEN | C_BACC, 5'd1, 10'h040, 1'b0, 1'b1);
    step(C_JUMP, 5'd1, 10'h040, 1'b0, 1'b1);
    step(C_NONE, '0, 10'h040, 1'b0, 1'b1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL priority[%0d]: got pc=%h valid=%b done=%b, expected pc=%h valid=%b done=%b",
                 k, o.pc, o.v, o.d, e.pc, e.v, e.d);
      end
      k++;
    end
  endtask

  task automatic test_falloff();
    obs_t e, o;
    int   k;
    do_reset();
    lut_write(5'd4, 10'h3FE, PW'(0), 1'b0, 1'b0);
    lut_write(5'd5, 10'h010, PW'(0), 1'b0, 1'b0);
    step(C_START, '0, PW'(0), 1'b1, 1'b0);
    for (int i = 1; i <= 1023; i++) step(C_NONE, '0, PW'(i), 1'b1, 1'b0);
    step(C_NONE, '0, 10'h3FF, 1'b0, 1'b1);
    step(C_NONE, '0, 10'h3FF, 1'b0, 1'b1);
    step(C_START, '0, PW'(0), 1'b1, 1'b0);
    step(C_JUMP, 5'd4, 10'h3FE, 1'b1, 1'b0);
    step(C_NONE, '0, 10'h3FF, 1'b1, 1'b0);
    step(C_JUMP, 5'd5, 10'h010, 1'b1, 1'b0);
    step(C_NONE, '0, 10'h011, 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL falloff[%0d]: got pc=%h valid=%b done=%b, expected pc=%h valid=%b done=%b",
                 k, o.pc, o.v, o.d, e.pc, e.v, e.d);
      end
      k++;
    end
  endtask

  task automatic test_lut_write_gating();
    obs_t e, o;
    int   k;
    do_reset();
    step(C_START, '0, PW'(0), 1'b1, 1'b0);
    lut_write(5'd2, 10'h0AA, PW'(1), 1'b1, 1'b0);
    step(C_JUMP, 5'd2, PW'(0), 1'b1, 1'b0);
    step(C_HALT, '0, PW'(0), 1'b0, 1'b1);
    lut_write(5'd2, 10'h0AA, PW'(0), 1'b0, 1'b1);
    step(C_START, '0, PW'(0), 1'b1, 1'b0);
    step(C_JUMP, 5'd2, 10'h0AA, 1'b1, 1'b0);
    step(C_HALT, '0, 10'h0AA, 1'b0, 1'b1);
    step(C_START, '0, PW'(0), 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL lut_gating[%0d]: got pc=%h valid=%b done=%b, expected pc=%h valid=%b done=%b",
                 k, o.pc, o.v, o.d, e.pc, e.v, e.d);
      end
      k++;
    end
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    int   k;
    do_reset();
    lut_write(5'd6, 10'h055, PW'(0), 1'b0, 1'b0);
    step(C_START, '0, PW'(0), 1'b1, 1'b0);
    step(C_JUMP, 5'd6, 10'h055, 1'b1, 1'b0);
    clear_inputs();
    #3;
    Reset_n = 1'b0;
    #1;
    exp_q.push_back({PW'(0), 1'b0, 1'b0});
    capture();
    @(posedge Clk);
    #1;
    exp_q.push_back({PW'(0), 1'b0, 1'b0});
    capture();
    Reset_n = 1'b1;
    step(C_START, '0, PW'(0), 1'b1, 1'b0);
    step(C_JUMP, 5'd6, PW'(0), 1'b1, 1'b0);
    step(C_NONE, '0, PW'(1), 1'b1, 1'b0);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: got pc=%h valid=%b done=%b, expected pc=%h valid=%b done=%b",
                 k, o.pc, o.v, o.d, e.pc, e.v, e.d);
      end
      k++;
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    Reset_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_falloff();
    test_lut_write_gating();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch sequencer. It sits directly upstream of the combinational control decoder.
- Drives the instruction ROM address and accepts the decoder's Jump/BranchEn/BranchAccept, halt and branch-index outputs. From these it computes the next PC each cycle.
- Owns the branch-target lookup table (LUT) that the 9-bit ISA uses to reach far addresses, and the Start/Done program handshake.

Parameters:
- PC_W, 10, program counter width (ROM depth 2^PC_W).
- LUT_IDX_W, 5, branch/jump index width (Instruction[4:0]); LUT depth 2^LUT_IDX_W.
- START_ADDR, 0, PC loaded on Start.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  level; begin or restart a program run.
- Jump  in  1  from decoder: unconditional jump.
- BranchEn  in  1  from decoder: current instruction is a conditional branch.
- BranchAccept  in  1  from decoder: branch condition true.
- Halt  in  1  from decoder: current instruction is the halt encoding.
- BranchIdx  in  LUT_IDX_W  LUT index from current instruction.
- LutWe  in  1  LUT write enable.
- LutWAddr  in  LUT_IDX_W  LUT write index.
- LutWData  in  PC_W  LUT write data (absolute target).
- ProgCtr  out  PC_W  instruction ROM address.
- InstrValid  out  1  ProgCtr addresses an instruction to execute this cycle.
- Done  out  1  program finished.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - state=IDLE, ProgCtr=0, InstrValid=0, Done=0.
  - All LUT entries=0.
  - Reset asserted mid-run aborts immediately; there is no partial-state retention.
- States:
  - IDLE: InstrValid=0, Done=0. Start=1 -> RUN; ProgCtr<=START_ADDR.
  - RUN: InstrValid=1. Decoder inputs are valid only here; they are ignored in IDLE/DONE.
  - DONE: InstrValid=0, Done=1, ProgCtr holds. Start=1 -> RUN, ProgCtr<=START_ADDR, Done<=0.
- RUN next-PC, priority high to low, registered on the rising edge:
  1. Halt=1 -> DONE; ProgCtr holds the halt address.
  2. Jump=1 -> ProgCtr<=LUT[BranchIdx].
  3. BranchEn=1 and BranchAccept=1 -> ProgCtr<=LUT[BranchIdx].
  4. BranchEn=1 and BranchAccept=0 -> ProgCtr<=ProgCtr+1.
  5. Otherwise -> ProgCtr<=ProgCtr+1.
- BranchAccept without BranchEn has no effect.
- Fall-off: sequential increment from ProgCtr = 2^PC_W-1 does not wrap. The block enters DONE with ProgCtr held at 2^PC_W-1. A taken jump/branch from that address is honoured normally.
- Start held high in RUN is ignored; no restart.
- Latency: one cycle per instruction. The next address appears the cycle after the decoder inputs are sampled. Done rises the cycle after Halt is sampled.
- LUT writes:
  - Synchronous, accepted only in IDLE or DONE. LutWe in RUN is ignored.
  - A write and a read of the same index in the same cycle: the read sees the old value. This can only occur at the IDLE->RUN/DONE->RUN transition, where no LUT read is used.
- LUT read: combinational, feeding the next-PC mux.
- Width rule: PC arithmetic is unsigned PC_W bits; LUT entries are absolute PC_W-bit addresses.

Decomposition:
- Shared definitions package:
  - fetch state enum {FS_IDLE, FS_RUN, FS_DONE} (2 bits).
  - HALT instruction encoding constant.
  - PC_W/LUT_IDX_W defaults, so the decoder and top level agree.
- One sub-module: branch_lut, a 2^LUT_IDX_W x PC_W register array with async reset, gated write port and combinational read.
- Next-PC mux and FSM stay in fetch_unit.

Test Plan:
1. Reset, Start pulse, no control inputs for 4 cycles -> ProgCtr 0,1,2,3,4; InstrValid=1 from the cycle after Start; Done=0.
2. In IDLE write LUT[3]=0x120; run; at ProgCtr=5 assert BranchEn=1, BranchAccept=1, BranchIdx=3 -> next ProgCtr=0x120. Repeat with BranchAccept=0 -> next ProgCtr=6.
3. Jump=1 and BranchEn=1/BranchAccept=1 in the same cycle with LUT[1]=0x040, BranchIdx=1 -> ProgCtr=0x040. Same cycle with Halt=1 -> DONE, ProgCtr holds, Done=1 next cycle.
4. Run from START_ADDR with ProgCtr reaching 0x3FF and no branch -> DONE, ProgCtr stays 0x3FF, no wrap to 0.
5. LutWe=1, LutWAddr=2, LutWData=0x0AA during RUN -> LUT[2] unchanged (later jump via idx 2 goes to old value 0). After Done, Start=1 -> ProgCtr=START_ADDR, Done=0 next cycle.
6. Reset_n driven low mid-cycle during RUN at ProgCtr=0x055 -> ProgCtr=0, InstrValid=0, Done=0 immediately (asynchronous), LUT cleared. Release then Start -> normal run from 0.
